uart_rx_sched: RTL
==================

// Module: uart_rx_sched
// PURPOSE
//  Receive-side controller for the UART receiver: watches its done strobe and data byte,
//  detects completed frames, and buffers the bytes in a DEPTH-entry FIFO.
//  Presents bytes to one downstream consumer through a valid/ready handshake.
//  Tracks overrun and accepted-byte count.
//  Runs entirely in the receiver's sampling-clock domain.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of 2, >= 2
//  AW      3   $clog2(DEPTH); pointer width; level is AW+1 bits
// PORTS
//  s_clk      in   1     sampling clock (same clock as the receiver FSM)
//  rst        in   1     reset, asynchronous, active-high
//  rx_en      in   1     1 = capture frames; 0 = ignore receiver, FIFO still drains
//  rx_done_i  in   1     receiver done/ready level (1 in idle and stop, 0 mid-frame)
//  rx_data_i  in   8     receiver output byte; valid when rx_done_i rises
//  m_data     out  8     FIFO head byte (show-ahead)
//  m_valid    out  1     FIFO non-empty
//  m_ready    in   1     consumer accepts m_data when m_valid && m_ready
//  level      out  AW+1  FIFO occupancy, 0..DEPTH
//  full       out  1     level == DEPTH
//  overrun    out  1     sticky: a completed frame was dropped because the FIFO was full
//  ovr_clr    in   1     synchronous clear of overrun
//  byte_cnt   out  16    bytes pushed into the FIFO since reset; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset (async): state=DISARMED.
//   Pointers=0. m_data=0, m_valid=0, level=0, full=0, overrun=0, byte_cnt=0.
//  Frame-tracking FSM (advances every s_clk):
//   DISARMED: wait for rx_done_i=1, then go to ARMED. No capture here.
//    This discards the receiver's reset-exit 0->1 transition.
//    It also discards any frame already in flight when rx_en is raised.
//   ARMED:    rx_done_i=0 -> RECV (start bit detected by the receiver).
//   RECV:     rx_done_i=1 -> capture cycle: sample rx_data_i, go to ARMED.
//   rx_en=0 in any state -> DISARMED next cycle. A capture in that same cycle is suppressed.
//  Capture = push request in the capture cycle.
//   Push succeeds if !full or a pop occurs in the same cycle.
//   Otherwise the byte is dropped and overrun is set.
//  Pop = m_valid && m_ready. Pop when empty is impossible (m_valid=0). m_ready alone is ignored.
//  Push and pop in the same cycle: both happen and level is unchanged.
//   This holds when full (no overrun) and when level=1.
//  Push into empty FIFO: m_valid=1 and m_data=byte on the next cycle (1-cycle latency).
//  Pointers wrap modulo DEPTH. level and full are registered and consistent with the pointers every cycle.
//  m_data is stable while m_valid && !m_ready.
//  overrun: set has priority over ovr_clr in the same cycle. Otherwise ovr_clr clears it.
//  byte_cnt increments on each successful push only; dropped bytes are not counted.
//  Reset mid-frame or mid-drain: all contents are lost and the FSM is DISARMED.
//   The first frame after reset is captured only after rx_done_i has been seen high.
// TESTING
//  1 Reset, hold rx_done_i=0 then 1, no frame -> no push; level=0, m_valid=0.
//  2 Frame 0xA5 (rx_done_i 1->0 for 9 cycles ->1), m_ready=0 -> m_data=0xA5, m_valid=1, level=1, byte_cnt=1.
//  3 9 frames 0x01..0x09, m_ready=0, DEPTH=8 -> level=8, full=1, overrun=1, byte_cnt=8.
//    Then drain -> 0x01..0x08 in order, empty.
//  4 FIFO full; capture cycle with m_ready=1 -> level stays 8, overrun stays 0.
//    Then ovr_clr and a dropped frame in the same cycle -> overrun=1.
//  5 Raise rx_en while rx_done_i=0 mid-frame -> that byte is discarded; next frame 0x3C is captured.
//    Deassert rx_en at the capture cycle -> no push.
//  6 Assert rst with level=3 mid-frame -> all outputs are 0 immediately; the next frame is captured normally.

Source files
------------

// File: rtl/uart_rx_sched.sv
// Receive-side scheduler for the UART receiver: detects completed frames from the
// receiver's done level, buffers bytes in a show-ahead FIFO and tracks overrun/count.
module uart_rx_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          s_clk,
  input  logic          rst,
  input  logic          rx_en,
  input  logic          rx_done_i,
  input  logic [7:0]    rx_data_i,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic [15:0]   byte_cnt
);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RECV     = 2'd2;

  logic [1:0]    state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_next;
  logic [7:0]    mem [DEPTH];
  logic          capture, push, pop, drop;

  // A capture is the receiver's done level rising while a frame is in progress.
  assign capture = rx_en && (state == ST_RECV) && rx_done_i;
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (!rx_en) begin
      state_next = ST_DISARMED;
    end else begin
      case (state)
        ST_DISARMED: if (rx_done_i)  state_next = ST_ARMED;
        ST_ARMED:    if (!rx_done_i) state_next = ST_RECV;
        ST_RECV:     if (rx_done_i)  state_next = ST_ARMED;
        default:                     state_next = ST_DISARMED;
      endcase
    end
  end

  always_comb begin
    level_next = level;
    if (push && !pop)      level_next = level + 1'b1;
    else if (pop && !push) level_next = level - 1'b1;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      state    <= ST_DISARMED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overrun  <= 1'b0;
      byte_cnt <= 16'h0000;
    end else begin
      state <= state_next;
      level <= level_next;
      full  <= (level_next == (AW+1)'(DEPTH));
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        byte_cnt <= byte_cnt + 16'h0001;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  // NOTE: storage is not reset; entries are only observable through m_valid-gated reads.
  always_ff @(posedge s_clk) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  // Empty FIFO presents zero rather than a stale or undefined entry.
  assign m_data = m_valid ? mem[rd_ptr] : 8'h00;

endmodule
